// File: rtl/muxout_deser_pkg.sv
// Shared types, default sizes and the bit-insertion helper for the MuxOut
// serial-to-parallel capture stage.
package muxout_deser_pkg;

  localparam int unsigned DESER_WIDTH = 4;
  localparam int unsigned DESER_CNT_W = 8;
  localparam int unsigned DESER_MAX_W = 16;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } deser_state_e;

  // MSB-first shifts left so the oldest bit ends up on top; LSB-first shifts
  // right and drops the new bit at position width-1 so the oldest lands at 0.
  function automatic logic [DESER_MAX_W-1:0] deser_insert(
    input logic [DESER_MAX_W-1:0] sh,
    input logic                   b,
    input int unsigned            width,
    input logic                   msb_first
  );
    logic [DESER_MAX_W-1:0] r;
    r = '0;
    if (msb_first) begin
      r = {sh[DESER_MAX_W-2:0], b};
    end else begin
      r = sh >> 1;
      r[width-1] = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/muxout_deser.sv
// Assembles WIDTH accepted MuxOut bits into a word presented on a
// valid/ready port, stalling the bit side when a finished word has no slot.
module muxout_deser
  import muxout_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DESER_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = DESER_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             align,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] word_count
);

  localparam int unsigned POS_W = $clog2(WIDTH);

  deser_state_e     state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_full_q, out_full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                   accept_s;
  logic                   transfer_s;
  logic                   slot_free_s;
  logic                   load_s;
  logic [WIDTH-1:0]       sh_base_s;
  logic [POS_W-1:0]       pos_base_s;
  logic [DESER_MAX_W-1:0] ins_s;
  logic [WIDTH-1:0]       word_s;
  logic                   ins_unused_s;

  assign bit_ready   = (state_q == FILL);
  assign accept_s    = bit_valid && bit_ready;
  assign transfer_s  = out_full_q && word_ready;
  assign slot_free_s = !out_full_q || transfer_s;

  // align only rewinds the word under construction, never a stalled one
  assign sh_base_s  = (align && state_q == FILL) ? '0 : sh_q;
  assign pos_base_s = (align && state_q == FILL) ? '0 : pos_q;
  assign ins_s      = deser_insert(DESER_MAX_W'(sh_base_s), bit_in, WIDTH, MSB_FIRST);
  assign word_s     = ins_s[WIDTH-1:0];
  assign ins_unused_s = ^(ins_s >> WIDTH);

  // Next-state for the FILL/STALL controller and the data path
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sh_d    = sh_q;
    out_d   = out_q;
    load_s  = 1'b0;
    case (state_q)
      FILL: begin
        if (accept_s) begin
          if (pos_base_s == POS_W'(WIDTH - 1)) begin
            pos_d = '0;
            if (slot_free_s) begin
              out_d  = word_s;
              sh_d   = '0;
              load_s = 1'b1;
            end else begin
              sh_d    = word_s;
              state_d = STALL;
            end
          end else begin
            sh_d  = word_s;
            pos_d = pos_base_s + POS_W'(1);
          end
        end else begin
          sh_d  = sh_base_s;
          pos_d = pos_base_s;
        end
      end
      STALL: begin
        pos_d = '0;
        if (transfer_s) begin
          out_d   = sh_q;
          sh_d    = '0;
          load_s  = 1'b1;
          state_d = FILL;
        end else begin
          state_d = STALL;
        end
      end
      default: begin
        state_d = FILL;
        pos_d   = '0;
        sh_d    = '0;
      end
    endcase

    if (load_s) begin
      out_full_d = 1'b1;
    end else if (transfer_s) begin
      out_full_d = 1'b0;
    end else begin
      out_full_d = out_full_q;
    end
    cnt_d = cnt_q + CNT_W'(transfer_s);
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      pos_q      <= '0;
      sh_q       <= '0;
      out_q      <= '0;
      out_full_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      sh_q       <= sh_d;
      out_q      <= out_d;
      out_full_q <= out_full_d;
      cnt_q      <= cnt_d;
    end
  end

  assign word_data  = out_q;
  assign word_valid = out_full_q;
  assign word_count = cnt_q;

endmodule

// File: tb/tb_muxout_deser.sv
// Directed bench for muxout_deser: one MSB-first and one LSB-first instance
// share the stimulus; expectations are hand-computed constants.
module tb_muxout_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       align = 1'b0;
  logic       word_ready = 1'b0;

  logic       m_bit_ready, m_word_valid;
  logic [3:0] m_word_data;
  logic [7:0] m_word_count;
  logic       l_bit_ready, l_word_valid;
  logic [3:0] l_word_data;
  logic [7:0] l_word_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  muxout_deser #(.WIDTH(4), .MSB_FIRST(1'b1), .CNT_W(8)) dut_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(m_bit_ready), .align(align), .word_data(m_word_data),
    .word_valid(m_word_valid), .word_ready(word_ready), .word_count(m_word_count)
  );

  muxout_deser #(.WIDTH(4), .MSB_FIRST(1'b0), .CNT_W(8)) dut_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(l_bit_ready), .align(align), .word_data(l_word_data),
    .word_valid(l_word_valid), .word_ready(word_ready), .word_count(l_word_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic al);
    bit_in    = b;
    bit_valid = 1'b1;
    align     = al;
    tick();
    bit_valid = 1'b0;
    align     = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) send_bit(w[i], 1'b0);
  endtask

  initial begin
    // reset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(m_word_valid), 32'd0);
    chk("rst_count", 32'(m_word_count), 32'd0);
    chk("rst_data",  32'(m_word_data),  32'd0);
    chk("rst_ready", 32'(m_bit_ready),  32'd1);

    // basic MSB-first capture, consumer always ready
    word_ready = 1'b1;
    send_word(4'b1111);
    chk("cap1_valid", 32'(m_word_valid), 32'd1);
    chk("cap1_data",  32'(m_word_data),  32'hF);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("cap2_gap_valid", 32'(m_word_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("cap2_data", 32'(m_word_data), 32'h5);
    chk("cap2_ready", 32'(m_bit_ready), 32'd1);
    send_word(4'b0011);
    chk("cap3_data", 32'(m_word_data), 32'h3);
    tick();
    chk("cap_count", 32'(m_word_count), 32'd3);
    chk("cap_drained", 32'(m_word_valid), 32'd0);

    // backpressure into STALL, then a one-cycle release
    word_ready = 1'b0;
    send_word(4'b1000);
    chk("bp1_data", 32'(m_word_data), 32'h8);
    send_word(4'b1010);
    chk("bp_stall_ready", 32'(m_bit_ready), 32'd0);
    chk("bp_hold_data", 32'(m_word_data), 32'h8);
    chk("bp_hold_valid", 32'(m_word_valid), 32'd1);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("bp2_data", 32'(m_word_data), 32'hA);
    chk("bp2_valid", 32'(m_word_valid), 32'd1);
    chk("bp_release_ready", 32'(m_bit_ready), 32'd1);
    chk("bp_count", 32'(m_word_count), 32'd4);
    word_ready = 1'b1;
    tick();
    chk("bp_drain_count", 32'(m_word_count), 32'd5);

    // align mid-word discards the partial 11
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("align_early_valid", 32'(m_word_valid), 32'd0);
    send_bit(1'b1, 1'b0);
    chk("align_data", 32'(m_word_data), 32'h7);
    tick();
    chk("align_count", 32'(m_word_count), 32'd6);

    // reset while stalled with an unconsumed word
    word_ready = 1'b0;
    send_word(4'b1100);
    send_word(4'b0110);
    chk("rst2_pre_stall", 32'(m_bit_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_valid", 32'(m_word_valid), 32'd0);
    chk("rst2_ready", 32'(m_bit_ready),  32'd1);
    chk("rst2_count", 32'(m_word_count), 32'd0);
    chk("rst2_data",  32'(m_word_data),  32'd0);

    // LSB-first word, then count wrap over 256 deliveries
    word_ready = 1'b1;
    send_word(4'b1011);
    chk("lsb_data",  32'(l_word_data),  32'hD);
    chk("lsb_valid", 32'(l_word_valid), 32'd1);
    for (int w = 1; w < 256; w++) send_word(4'(w));
    chk("wrap_pre_count", 32'(l_word_count), 32'd255);
    chk("wrap_ready", 32'(l_bit_ready), 32'd1);
    tick();
    chk("wrap_count", 32'(l_word_count), 32'd0);
    chk("wrap_valid", 32'(l_word_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muxout_deser.md
Name: muxout_deser

Overview:
Serial-to-parallel capture stage directly downstream of the 4:1 select mux (HW1).
- Each cycle it may sample the mux output bit (MuxOut) and assemble WIDTH consecutive accepted bits into one word.
- The word is presented on a valid/ready output port.
- It lets the bench and later stages check mux selections as whole words rather than single bits.

Parameters:
WIDTH, 4, bits per assembled word (legal range 2..16).
MSB_FIRST, 1, 1: first accepted bit lands in word_data[WIDTH-1]; 0: first bit lands in word_data[0].
CNT_W, 8, width of the wrapping completed-word counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
bit_in  input  1  serial data, connected to mux MuxOut.
bit_valid  input  1  bit_in is meaningful this cycle.
bit_ready  output  1  block can accept a bit this cycle.
align  input  1  discards the partial word and restarts bit position at 0.
word_data  output  WIDTH  assembled word, stable while word_valid=1.
word_valid  output  1  word_data holds an unconsumed word.
word_ready  input  1  consumer accepts word this cycle.
word_count  output  CNT_W  number of words delivered (word_valid&&word_ready), wraps at 2^CNT_W.

Behaviour:
- Bit acceptance: a bit is accepted when bit_valid && bit_ready. A word transfer happens when word_valid && word_ready.
- Internal state: shift register sh[WIDTH-1:0], position counter pos (0..WIDTH-1), output register out_q, out_full flag, 2-state FSM {FILL, STALL}.
- Reset, applied on the clock edge with rst=1:
  - state=FILL, pos=0, sh=0.
  - word_data=0, word_valid=0, word_count=0.
  - bit_ready=1 in the cycle after reset.
  - rst overrides every other input. Reset mid-word discards the partial word and any held or unconsumed word.
- bit_ready = (state==FILL). It is combinational from state only and never depends on bit_valid.
- "slot_free" = !out_full || (word_valid && word_ready).
- FILL, accepted bit with pos<WIDTH-1: shift bit into sh per MSB_FIRST; pos+1.
- FILL, accepted bit with pos==WIDTH-1 (word complete):
  - If slot_free: out_q <= completed word (including this bit), word_valid=1 next cycle, pos=0, stay FILL.
  - Else: sh <= completed word, go to STALL.
- STALL:
  - bit_ready=0 and pos holds at 0.
  - When word_valid && word_ready: out_q <= sh, word_valid stays 1, go to FILL.
- Output side:
  - A word transfer with no new load clears word_valid next cycle.
  - A transfer and a load in the same cycle keep word_valid=1 with the new data; no bubble.
  - word_count increments on every transfer and wraps from 2^CNT_W-1 to 0.
- Latency: word_valid rises exactly 1 cycle after the edge that accepted the last bit, provided the slot was free.
- Throughput: with word_ready held 1, one word every WIDTH accepted bits, and bit_ready never drops.
- align:
  - In FILL: pos=0 and sh=0. If a bit is accepted in the same cycle, it becomes bit 0 of the new word (pos=1 next).
  - In STALL: no effect; a completed word is never discarded.
  - align never affects out_q, word_valid or word_count.
- Gaps: bit_valid=0 cycles simply hold state; there is no timeout.
- Unaccepted bits: a bit presented while bit_ready=0 is not captured. The upstream stage must hold it until bit_ready=1.

Decomposition:
- Package muxout_deser_pkg holds:
  - the state enum {FILL, STALL};
  - default constants DESER_WIDTH=4 and DESER_CNT_W=8;
  - a helper function for MSB/LSB-first insertion into the shift register.
- No sub-module is needed; one module with a single sequential process plus combinational ready/slot logic.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles, then release -> word_valid=0, word_count=0, word_data=0, bit_ready=1.
- Basic capture: WIDTH=4, MSB_FIRST=1, word_ready=1, bits 1,1,1,1 then 0,1,0,1 then 0,0,1,1 -> word_data=4'b1111, 4'b0101, 4'b0011 with word_valid one cycle after each 4th bit; word_count=3.
- Backpressure: word_ready=0, stream 1,0,0,0 then 1,0,1,0 -> first word 4'b1000 holds, FSM enters STALL, bit_ready=0. Raise word_ready for 1 cycle -> 4'b1010 appears next cycle, bit_ready returns to 1.
- align mid-word: bits 1,1 then align+bit 0, then bits 1,1,1 -> next word 4'b0111; partial 11 discarded.
- LSB-first and wrap: MSB_FIRST=0, bits 1,0,1,1 -> word_data=4'b1101. Deliver 256 words with CNT_W=8 -> word_count wraps to 0.
- Reset mid-operation: rst during STALL with word_valid=1 -> next cycle word_valid=0, state FILL, bit_ready=1, word_count=0.
